pc_sequencer: RTL and testbench

Program-counter and fetch sequencer that sits directly upstream of the MIPS core. It owns the 8-bit PC and drives the core's instruction read address. Each cycle it consumes the core's control-flow outputs (SEImm, JumpValue, Zero, Branch, Jump) to select the next PC. It also provides run/halt status and a retired-instruction counter so the top level can start, stall and observe execution.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 40 ++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the PC/fetch sequencer: state encoding, datapath
// widths and the saturating counter helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } seq_state_e;

  localparam int PC_W      = 8;
  localparam int PC_STRIDE = 4;
  localparam int CNT_W     = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC selection: sequential address, branch and jump targets, priority
// mux and detection of a taken transfer back onto the current PC.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [5:0]      imm_lo,
  input  logic [5:0]      jump_lo,
  input  logic            zero,
  input  logic            branch,
  input  logic            jump,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] next_pc,
  output logic            redirect,
  output logic            self_loop
);

  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] branch_target;

  // Targets are word-aligned; only the low immediate bits reach the 8-bit PC.
  assign pc_plus4      = pc + PC_W'(PC_STRIDE);
  assign jump_target   = {jump_lo, 2'b00};
  assign branch_target = pc_plus4 + {imm_lo, 2'b00};

  // Jump outranks a taken branch; an untaken branch falls through.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (jump) begin
      next_pc  = jump_target;
      redirect = 1'b1;
    end else if (branch && zero) begin
      next_pc  = branch_target;
      redirect = 1'b1;
    end
    self_loop = redirect && (next_pc == pc);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the MIPS core: IDLE/RUN/HALT
// control, PC register, saturating retired-instruction counter.
// Optional macro ADDR_TRAP_EN enables the out-of-range fetch trap.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int IMEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Go,
  input  logic              Stall,
  input  logic              Zero,
  input  logic              Branch,
  input  logic              Jump,
  input  logic [31:0]       SEImm,
  input  logic [25:0]       JumpValue,
  output logic [PC_W-1:0]   ReadAddr,
  output logic [PC_W-1:0]   PCPlus4,
  output logic              Running,
  output logic              Halted,
  output logic              Trap,
  output logic [CNT_W-1:0]  InstrCount
);

`ifdef ADDR_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;

  logic [PC_W-1:0]  next_pc;
  logic             redirect;
  logic             self_loop;
  logic             beyond_imem;
  logic             trap_hit;

  // Upper immediate/jump bits cannot affect an 8-bit PC.
  logic unused_ctl_bits;
  assign unused_ctl_bits = ^{SEImm[31:6], JumpValue[25:6], redirect};

  pc_target_calc u_target (
    .pc        (pc_q),
    .imm_lo    (SEImm[5:0]),
    .jump_lo   (JumpValue[5:0]),
    .zero      (Zero),
    .branch    (Branch),
    .jump      (Jump),
    .pc_plus4  (PCPlus4),
    .next_pc   (next_pc),
    .redirect  (redirect),
    .self_loop (self_loop)
  );

  assign beyond_imem = ({24'b0, next_pc} >= 32'(IMEM_BYTES));
  assign trap_hit    = TRAP_EN && beyond_imem;

  // Next-state, PC, counter and trap selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    trap_d  = trap_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (Go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!Stall) begin
          // The instruction at the current PC retires even if it halts.
          cnt_d = sat_inc(cnt_q);
          if (trap_hit) begin
            state_d = ST_HALT;
            trap_d  = 1'b1;
          end else if (self_loop) begin
            state_d = ST_HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign ReadAddr   = pc_q;
  assign Running    = (state_q == ST_RUN);
  assign Halted     = (state_q == ST_HALT);
  assign Trap       = trap_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, randomized
// stimulus and a counter-saturation run against a behavioural model.
module tb_pc_sequencer;

`ifdef ADDR_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int IMEM = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Go = 1'b0, Stall = 1'b0, Zero = 1'b0, Branch = 1'b0, Jump = 1'b0;
  logic [31:0] SEImm = '0;
  logic [25:0] JumpValue = '0;
  logic [7:0]  ReadAddr, PCPlus4;
  logic        Running, Halted, Trap;
  logic [15:0] InstrCount;

  int total = 0;
  int bad   = 0;
  bit verbose = 1'b1;

  // Reference model: plain integers and mode flags.
  int m_pc = 0, m_cnt = 0;
  bit m_run = 0, m_halt = 0, m_trap = 0;

  pc_sequencer #(.IMEM_BYTES(IMEM)) dut (
    .clk(clk), .reset(reset), .Go(Go), .Stall(Stall), .Zero(Zero),
    .Branch(Branch), .Jump(Jump), .SEImm(SEImm), .JumpValue(JumpValue),
    .ReadAddr(ReadAddr), .PCPlus4(PCPlus4), .Running(Running),
    .Halted(Halted), .Trap(Trap), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, go, stall, zero, br, jmp,
                              input logic [31:0] imm, input logic [25:0] jv);
    int seq, nxt;
    bit taken;
    if (rst) begin
      m_pc = 0; m_cnt = 0; m_run = 0; m_halt = 0; m_trap = 0;
    end else if (!m_run && !m_halt) begin
      m_pc = 0;
      if (go) m_run = 1;
    end else if (m_run && !stall) begin
      seq = (m_pc + 4) % 256;
      nxt = seq;
      taken = 0;
      if (jmp) begin
        nxt = int'(jv[5:0]) * 4;
        taken = 1;
      end else if (br && zero) begin
        nxt = (seq + int'(imm[5:0]) * 4) % 256;
        taken = 1;
      end
      if (m_cnt < 65535) m_cnt++;
      if (TRAP && nxt >= IMEM) begin
        m_run = 0; m_halt = 1; m_trap = 1;
      end else if (taken && nxt == m_pc) begin
        m_run = 0; m_halt = 1;
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  task automatic check_all();
    check("ReadAddr",   {24'b0, ReadAddr},   32'(m_pc));
    check("PCPlus4",    {24'b0, PCPlus4},    32'((m_pc + 4) % 256));
    check("Running",    {31'b0, Running},    32'(m_run));
    check("Halted",     {31'b0, Halted},     32'(m_halt));
    check("Trap",       {31'b0, Trap},       32'(m_trap));
    check("InstrCount", {16'b0, InstrCount}, 32'(m_cnt));
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic step(input bit rst, go, stall, zero, br, jmp,
                      input logic [31:0] imm, input logic [25:0] jv);
    @(negedge clk);
    reset = rst; Go = go; Stall = stall; Zero = zero; Branch = br; Jump = jmp;
    SEImm = imm; JumpValue = jv;
    @(posedge clk);
    model_update(rst, go, stall, zero, br, jmp, imm, jv);
    #1;
    check_all();
    if (verbose)
      $display("txn rst=%0b go=%0b stall=%0b br=%0b z=%0b j=%0b -> addr=%02h cnt=%0d run=%0b halt=%0b trap=%0b",
               rst, go, stall, br, zero, jmp, ReadAddr, InstrCount, Running, Halted, Trap);
  endtask

  task automatic do_reset();  step(1, 0, 0, 0, 0, 0, 32'h0, 26'h0); endtask
  task automatic do_go();     step(0, 1, 0, 0, 0, 0, 32'h0, 26'h0); endtask
  task automatic do_seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 26'h0);
  endtask
  task automatic jump_to(input int addr);
    step(0, 0, 0, 0, 0, 1, 32'h0, 26'(addr / 4));
  endtask

  initial begin
    // Reset values.
    do_reset();
    do_reset();
    check("rst_addr",  {24'b0, ReadAddr}, 32'h0);
    check("rst_plus4", {24'b0, PCPlus4},  32'h4);

    // Go then five sequential instructions.
    do_go();
    check("go_running", {31'b0, Running}, 32'h1);
    do_seq(5);
    check("seq_addr", {24'b0, ReadAddr}, 32'h14);
    check("seq_cnt",  {16'b0, InstrCount}, 32'd5);

    // Backward branch taken from 0x10, then untaken branch from 0x10.
    jump_to(8'h10);
    step(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFE, 26'h0);
    check("br_taken", {24'b0, ReadAddr}, 32'h0C);
    jump_to(8'h10);
    step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE, 26'h0);
    check("br_untaken", {24'b0, ReadAddr}, 32'h14);

    // Self-loop jump at 0x08 halts; Go afterwards ignored.
    do_reset(); do_go();
    jump_to(8'h08);
    step(0, 0, 0, 0, 0, 1, 32'h0, 26'h000002);
    check("loop_halt", {31'b0, Halted}, 32'h1);
    check("loop_cnt",  {16'b0, InstrCount}, 32'd2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 32'h0, 26'h10);
    check("halt_frozen", {24'b0, ReadAddr}, 32'h08);

    // Stall holds a pending jump at 0x20.
    do_reset(); do_go();
    jump_to(8'h20);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1, 32'h0, 26'h10);
    check("stall_addr", {24'b0, ReadAddr}, 32'h20);
    check("stall_cnt",  {16'b0, InstrCount}, 32'd1);
    step(0, 0, 0, 0, 0, 1, 32'h0, 26'h10);
    check("stall_release", {24'b0, ReadAddr}, 32'h40);

    // Reset mid-run at 0x40 with count 16.
    do_reset(); do_go();
    do_seq(16);
    check("pre_rst_addr", {24'b0, ReadAddr}, 32'h40);
    step(1, 1, 0, 1, 1, 1, 32'h3, 26'h5);
    check("mid_rst_addr", {24'b0, ReadAddr}, 32'h0);
    check("mid_rst_cnt",  {16'b0, InstrCount}, 32'd0);

    // Sequential fetch from the last in-range word.
    do_go();
    jump_to(8'h7C);
    do_seq(1);
    check("edge_addr", {24'b0, ReadAddr}, TRAP ? 32'h7C : 32'h80);
    check("edge_trap", {31'b0, Trap}, 32'(TRAP));

    // Randomized control flow, stalls, Go and occasional reset.
    verbose = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           $urandom, 26'($urandom));
    end
    $display("random phase finished, transactions=400");

    // Counter saturation: keep the PC moving inside the memory window.
    do_reset(); do_go();
    for (int i = 0; i < 65540; i++) jump_to((m_pc + 4) % IMEM);
    check("sat_cnt",     {16'b0, InstrCount}, 32'hFFFF);
    check("sat_running", {31'b0, Running}, 32'h1);
    $display("saturation phase finished, count=%0h", InstrCount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
